clk1_gate_ctrl: RTL and testbench

Clock-gating controller for the clk1 domain. It generates the `en1` enable consumed by the clock/reset block's `clk1 & en1` gate. It watches local activity and a wake request from the clk2 domain, quiesces downstream logic through a 4-phase req/ack handshake, and then drops `en1`. The controller itself runs on ungated `clk1`, and `en1` changes only while `clk1` is low, so the AND gate stays glitch-free.

---
 rtl/clk_gate_pkg.sv | 16 +
 rtl/clk1_gate_ctrl_sync_bit.sv | 30 +++
 rtl/clk1_gate_ctrl.sv | 140 ++++++++++++++
 tb/tb_clk1_gate_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gate_pkg.sv
// Shared types and default parameters for the clk1 clock-gating controller.
package clk_gate_pkg;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_SETTLE = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_REQ     = 3'd1,
    ST_GATED   = 3'd2,
    ST_WAKE    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_e;

endpackage

// File: rtl/clk1_gate_ctrl_sync_bit.sv
// N-stage single-bit synchronizer with asynchronous active-low reset to 0.
module sync_bit
  import clk_gate_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/clk1_gate_ctrl.sv
// Clock-gating controller for clk1: idle detection, 4-phase quiesce handshake,
// and a negedge-registered enable so the downstream AND gate never glitches.
module clk1_gate_ctrl
  import clk_gate_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_SETTLE = DEF_WAKE_SETTLE,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk1,
  input  logic       rst_n1,
  input  logic       busy,
  input  logic       force_on,
  input  logic       wake_async,
  input  logic       quiesce_ack,
  output logic       quiesce_req,
  output logic       en1,
  output logic       gated,
  output logic [2:0] state
);

  localparam int IW = $clog2(IDLE_CYCLES);
  localparam int SW = $clog2(WAKE_SETTLE + 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(WAKE_SETTLE - 1);

  gate_state_e   state_q;
  gate_state_e   state_d;
  logic [IW-1:0] idle_cnt_q;
  logic [IW-1:0] idle_cnt_d;
  logic [SW-1:0] settle_cnt_q;
  logic [SW-1:0] settle_cnt_d;
  logic          en_q;
  logic          en_d;
  logic          en1_q;
  logic          en1_d;
  logic          quiesce_req_q;
  logic          quiesce_req_d;
  logic          gated_q;
  logic          gated_d;
  logic          wake_s;
  logic          active;

  sync_bit #(
    .STAGES(SYNC_STAGES)
  ) u_wake_sync (
    .clk  (clk1),
    .rst_n(rst_n1),
    .d    (wake_async),
    .q    (wake_s)
  );

  assign active = busy | force_on | wake_s;

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (active) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_MAX) begin
          state_d = ST_REQ;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      // An abort beats a simultaneous acknowledge.
      ST_REQ: begin
        if (active) begin
          state_d = ST_RELEASE;
        end else if (quiesce_ack) begin
          state_d = ST_GATED;
        end
      end
      ST_GATED: begin
        if (active) begin
          state_d      = ST_WAKE;
          settle_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (settle_cnt_q == SETTLE_MAX) begin
          state_d = ST_RELEASE;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!quiesce_ack) begin
          state_d    = ST_RUN;
          idle_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase

    // Outputs decode the next state so they register on the same edge.
    en_d          = (state_d != ST_GATED);
    quiesce_req_d = (state_d == ST_REQ) || (state_d == ST_GATED) || (state_d == ST_WAKE);
    gated_d       = (state_d == ST_GATED);
    en1_d         = en_q;
  end

  always_ff @(posedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      state_q       <= ST_RUN;
      idle_cnt_q    <= '0;
      settle_cnt_q  <= '0;
      en_q          <= 1'b1;
      quiesce_req_q <= 1'b0;
      gated_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      settle_cnt_q  <= settle_cnt_d;
      en_q          <= en_d;
      quiesce_req_q <= quiesce_req_d;
      gated_q       <= gated_d;
    end
  end

  // Updating on the falling edge keeps en1 stable while clk1 is high.
  always_ff @(negedge clk1 or negedge rst_n1) begin
    if (!rst_n1) begin
      en1_q <= 1'b1;
    end else begin
      en1_q <= en1_d;
    end
  end

  assign quiesce_req = quiesce_req_q;
  assign en1         = en1_q;
  assign gated       = gated_q;
  assign state       = state_q;

endmodule

// File: tb/tb_clk1_gate_ctrl.sv
// Self-checking bench for clk1_gate_ctrl: directed scenarios plus a long
// randomized run compared every cycle against a cycle-stamp based model.
module tb_clk1_gate_ctrl;

  localparam int IDLE   = 16;
  localparam int SETTLE = 2;
  localparam int SYNC   = 2;

  localparam int P_RUN   = 0;
  localparam int P_REQ   = 1;
  localparam int P_GATED = 2;
  localparam int P_WAKE  = 3;
  localparam int P_REL   = 4;

  logic       clk1        = 1'b0;
  logic       rst_n1      = 1'b0;
  logic       busy        = 1'b0;
  logic       force_on    = 1'b0;
  logic       wake_async  = 1'b0;
  logic       quiesce_ack = 1'b0;
  logic       quiesce_req;
  logic       en1;
  logic       gated;
  logic [2:0] state;

  int tests    = 0;
  int fails    = 0;
  bit check_en = 1'b0;

  int m_ph      = P_RUN;
  int m_idle    = 0;
  int m_cyc     = 0;
  int m_wake_at = 0;
  bit m_hist[$];

  clk1_gate_ctrl #(
    .IDLE_CYCLES(IDLE),
    .WAKE_SETTLE(SETTLE),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk1       (clk1),
    .rst_n1     (rst_n1),
    .busy       (busy),
    .force_on   (force_on),
    .wake_async (wake_async),
    .quiesce_ack(quiesce_ack),
    .quiesce_req(quiesce_req),
    .en1        (en1),
    .gated      (gated),
    .state      (state)
  );

  initial forever #5 clk1 = ~clk1;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after a posedge; a wake change lands at a random later point in the cycle.
  task automatic applyStimulus(input bit b, input bit f, input bit w, input bit auto_ack, input bit a);
    @(posedge clk1);
    #1;
    busy        = b;
    force_on    = f;
    quiesce_ack = auto_ack ? quiesce_req : a;
    if (w != wake_async) begin
      #($urandom_range(0, 6));
      wake_async = w;
    end
  endtask

  // Model: wake is seen SYNC posedges after it was sampled; phases advance by counting idle edges and cycle stamps.
  always @(posedge clk1 or negedge rst_n1) begin
    bit ws;
    bit act;
    if (!rst_n1) begin
      m_ph   <= P_RUN;
      m_idle <= 0;
      m_cyc  <= 0;
      m_hist.delete();
    end else begin
      ws = (m_hist.size() >= SYNC) ? m_hist[m_hist.size() - SYNC] : 1'b0;
      m_hist.push_back(wake_async);
      if (m_hist.size() > SYNC + 2) void'(m_hist.pop_front());
      act = busy | force_on | ws;
      m_cyc <= m_cyc + 1;
      case (m_ph)
        P_RUN: begin
          if (act) m_idle <= 0;
          else if (m_idle + 1 == IDLE) begin
            m_ph   <= P_REQ;
            m_idle <= 0;
          end else m_idle <= m_idle + 1;
        end
        P_REQ: begin
          if (act) m_ph <= P_REL;
          else if (quiesce_ack) m_ph <= P_GATED;
        end
        P_GATED: begin
          if (act) begin
            m_ph      <= P_WAKE;
            m_wake_at <= m_cyc + 1;
          end
        end
        P_WAKE: begin
          if (m_cyc + 1 - m_wake_at == SETTLE) m_ph <= P_REL;
        end
        default: begin
          if (!quiesce_ack) begin
            m_ph   <= P_RUN;
            m_idle <= 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk1) begin
    #1;
    if (check_en && rst_n1 === 1'b1) begin
      checkOutput("state", int'(state), m_ph);
      checkOutput("quiesce_req", int'(quiesce_req), (m_ph >= P_REQ && m_ph <= P_WAKE) ? 1 : 0);
      checkOutput("gated", int'(gated), (m_ph == P_GATED) ? 1 : 0);
      checkOutput("en1", int'(en1), (m_ph != P_GATED) ? 1 : 0);
      if (!en1) checkOutput("en1_low_implies_req", int'(quiesce_req), 1);
    end
  end

  always @(en1) begin
    if (rst_n1 === 1'b1) checkOutput("en1_changes_only_clk1_low", int'(clk1), 0);
  end

  initial begin
    int  cyc;
    bit  w;
    int  gated_seen;
    logic a;

    repeat (3) @(posedge clk1);
    @(negedge clk1);
    #1;
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_req", int'(quiesce_req), 0);
    checkOutput("reset_gated", int'(gated), 0);
    checkOutput("reset_en1", int'(en1), 1);
    #1;
    rst_n1   = 1'b1;
    check_en = 1'b1;

    // Idle from reset with auto-acknowledge.
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (quiesce_req) begin cyc = i; break; end
    end
    checkOutput("idle_cycles_to_req", cyc, IDLE);
    checkOutput("model_in_req", m_ph, P_REQ);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (gated) begin cyc = i; break; end
    end
    checkOutput("req_to_gated_cycles", cyc, 1);
    @(negedge clk1);
    #1;
    checkOutput("en1_low_when_gated", int'(en1), 0);

    // Asynchronous wake from GATED.
    applyStimulus(0, 0, 1, 1, 0);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 1, 1, 0);
      if (state == 3'd3) begin cyc = i; break; end
    end
    checkOutput("wake_to_wake_state_cycles", cyc, SYNC + 1);
    @(negedge clk1);
    #1;
    checkOutput("en1_after_wake", int'(en1), 1);
    cyc = -1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(0, 0, 1, 1, 0);
      if (!quiesce_req) begin cyc = i; break; end
    end
    checkOutput("wake_settle_cycles", cyc, SETTLE);
    checkOutput("state_release_after_wake", int'(state), 4);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("state_run_after_release", int'(state), 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Abort in REQ with a simultaneous acknowledge.
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (quiesce_req) begin cyc = i; break; end
    end
    checkOutput("abort_req_reached", (cyc > 0) ? 1 : 0, 1);
    applyStimulus(1, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("abort_state_release", int'(state), 4);
    checkOutput("abort_req_low", int'(quiesce_req), 0);
    checkOutput("abort_en1_high", int'(en1), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("abort_hold_release", int'(state), 4);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort_back_to_run", int'(state), 0);

    // force_on holds the clock and the idle counter.
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      if (i >= 2) begin
        checkOutput("force_idle_cnt", int'(dut.idle_cnt_q), 0);
        checkOutput("force_req_low", int'(quiesce_req), 0);
      end
    end
    applyStimulus(0, 0, 0, 0, 0);

    // Reset asserted while gated, with clk1 high.
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      applyStimulus(0, 0, 0, 1, 0);
      if (gated) begin cyc = i; break; end
    end
    checkOutput("gated_before_reset", (cyc > 0) ? 1 : 0, 1);
    @(negedge clk1);
    #1;
    checkOutput("en1_low_before_reset", int'(en1), 0);
    @(posedge clk1);
    #2;
    rst_n1 = 1'b0;
    #1;
    checkOutput("async_reset_en1", int'(en1), 1);
    checkOutput("async_reset_req", int'(quiesce_req), 0);
    checkOutput("async_reset_state", int'(state), 0);
    checkOutput("async_reset_gated", int'(gated), 0);
    checkOutput("async_reset_clk_high", int'(clk1), 1);
    repeat (2) @(posedge clk1);
    @(negedge clk1);
    #2;
    rst_n1 = 1'b1;

    // Randomized busy/wake/ack run.
    w          = 1'b0;
    gated_seen = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 59) == 0) w = ~w;
      a = ($urandom_range(0, 3) != 0) ? quiesce_req : quiesce_ack;
      applyStimulus(($urandom_range(0, 29) == 0), ($urandom_range(0, 199) == 0), w, 0, a);
      if (gated) gated_seen++;
    end
    checkOutput("random_gated_reached", (gated_seen > 0) ? 1 : 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
